hex_keypad_scanner: RTL

Scans a 4x4 matrix hex keypad and turns debounced key presses into hex digits that shift into a 16-bit entry register. It is the input-side counterpart of the multiplexed seven-segment display path. The display strobes anodes and drives cathodes; this block strobes keypad columns and reads rows back. Its `number` output connects directly to the display's 16-bit number input, so typed digits appear right-justified and scroll left.

---
 rtl/hex_keypad_scanner.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/hex_keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hex_keypad_scanner
//  Description : 4x4 hex keypad column scanner with debounce; accepted digits
//                shift into a 16-bit entry register.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_keypad_scanner #(
    parameter int SCAN_DIV       = 200000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    input  logic        clear,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] number
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_SCANS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]         r_rows_meta;
    logic [3:0]         r_rows_sync;
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_col;
    logic [3:0]         r_cols;
    logic [1:0]         r_acc_hits;
    logic [3:0]         r_acc_code;
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_cand;
    logic               r_key_valid;
    logic [3:0]         r_key_code;
    logic               r_key_held;
    logic [15:0]        r_number;

    logic [2:0]         w_col_hits;
    logic [3:0]         w_col_code;
    logic [2:0]         w_sum;
    logic [1:0]         w_scan_hits;
    logic [3:0]         w_scan_code;
    logic               w_sample;
    logic               w_scan_done;
    logic               w_none;
    logic               w_single;
    logic               w_accept;
    logic [3:0]         w_accept_code;
    logic [c_CNT_W-1:0] w_cnt_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rows_meta <= 4'b1111;
            r_rows_sync <= 4'b1111;
        end else begin
            r_rows_meta <= rows;
            r_rows_sync <= r_rows_meta;
        end
    end

    // Hits in the current column merged with the earlier columns of this scan;
    // the count saturates at 2 since only NONE/SINGLE/MULTI matter.
    always_comb begin
        w_col_hits = 3'd0;
        w_col_code = 4'h0;
        for (int r = 3; r >= 0; r--) begin
            if (!r_rows_sync[r]) begin
                w_col_hits = w_col_hits + 3'd1;
                w_col_code = key_map(2'(r), r_col);
            end
        end
        w_sum       = {1'b0, r_acc_hits} + w_col_hits;
        w_scan_hits = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_scan_code = (r_acc_hits == 2'd1) ? r_acc_code : w_col_code;
    end

    assign w_sample    = (r_div == c_DIV_LAST);
    assign w_scan_done = w_sample && (r_col == 2'd3);
    assign w_none      = (w_scan_hits == 2'd0);
    assign w_single    = (w_scan_hits == 2'd1);
    assign w_cnt_inc   = r_cnt + c_CNT_ONE;

    always_comb begin
        w_accept      = 1'b0;
        w_accept_code = r_cand;
        if (w_scan_done && w_single) begin
            if (r_state == S_IDLE && DEBOUNCE_SCANS == 1) begin
                w_accept      = 1'b1;
                w_accept_code = w_scan_code;
            end else if (r_state == S_DEBOUNCE && w_scan_code == r_cand
                         && w_cnt_inc == c_CNT_LAST) begin
                w_accept = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div      <= '0;
            r_col      <= 2'd0;
            r_cols     <= 4'b1110;
            r_acc_hits <= 2'd0;
            r_acc_code <= 4'h0;
        end else if (w_sample) begin
            r_div  <= '0;
            r_col  <= r_col + 2'd1;
            r_cols <= {r_cols[2:0], r_cols[3]};
            if (r_col == 2'd3) begin
                r_acc_hits <= 2'd0;
                r_acc_code <= 4'h0;
            end else begin
                r_acc_hits <= w_scan_hits;
                r_acc_code <= w_scan_code;
            end
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cand      <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_key_held  <= 1'b0;
            r_number    <= 16'h0000;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept)
                r_key_code <= w_accept_code;
            if (w_accept && clear)
                r_number <= {12'h000, w_accept_code};
            else if (w_accept)
                r_number <= {r_number[11:0], w_accept_code};
            else if (clear)
                r_number <= 16'h0000;

            if (w_scan_done) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_single) begin
                            r_cand <= w_scan_code;
                            r_cnt  <= c_CNT_ONE;
                            if (DEBOUNCE_SCANS == 1) begin
                                r_state    <= S_PRESSED;
                                r_key_held <= 1'b1;
                            end else begin
                                r_state <= S_DEBOUNCE;
                            end
                        end
                    end
                    S_DEBOUNCE: begin
                        if (w_single && w_scan_code == r_cand) begin
                            r_cnt <= w_cnt_inc;
                            if (w_accept) begin
                                r_state    <= S_PRESSED;
                                r_key_held <= 1'b1;
                            end
                        end else if (w_single) begin
                            r_cand <= w_scan_code;
                            r_cnt  <= c_CNT_ONE;
                        end else begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    S_PRESSED: begin
                        if (w_none) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                r_state    <= S_IDLE;
                                r_cnt      <= '0;
                                r_key_held <= 1'b0;
                            end else begin
                                r_state <= S_RELEASE;
                                r_cnt   <= c_CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        if (w_none) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == c_CNT_LAST) begin
                                r_state    <= S_IDLE;
                                r_cnt      <= '0;
                                r_key_held <= 1'b0;
                            end
                        end else begin
                            r_state <= S_PRESSED;
                        end
                    end
                endcase
            end
        end
    end

    assign cols      = r_cols;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_held  = r_key_held;
    assign number    = r_number;

endmodule
`default_nettype wire
